// File: rtl/otter_pkg.sv
// Shared OTTER types: PC source encoding, fetch FSM states and the redirect target bundle.
package otter_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PCSRC_W = 4;

  // Canonical no-op: addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // PC source encoding, shared with the control-unit decoder; 6..15 are reserved
  typedef enum logic [PCSRC_W-1:0] {
    PC_PLUS4  = 4'd0,
    PC_JALR   = 4'd1,
    PC_BRANCH = 4'd2,
    PC_JAL    = 4'd3,
    PC_MTVEC  = 4'd4,
    PC_MEPC   = 4'd5
  } pcsource_t;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // Every candidate non-sequential fetch target
  typedef struct packed {
    logic [XLEN-1:0] jalr;
    logic [XLEN-1:0] branch;
    logic [XLEN-1:0] jal;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
  } fetch_targets_t;

  // Clear the byte offset so fetches are always word aligned
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/otter_pc_sel.sv
// Next-PC selection: redirect detection, target priority, alignment and sequential advance.
module otter_pc_sel
  import otter_pkg::*;
(
  input  logic [XLEN-1:0]    pc_q,
  input  logic               fill,
  input  logic               if_stall,
  input  logic [PCSRC_W-1:0] pcsource,
  input  logic               int_taken,
  input  fetch_targets_t     targets,
  output logic               redirect_c,
  output logic [XLEN-1:0]    pc_next_c
);

  logic [XLEN-1:0] target;

  // Interrupt overrides whatever EX asked for; reserved encodings fall through as sequential
  always_comb begin
    redirect_c = int_taken;
    target     = pc_q;
    case (pcsource)
      PC_JALR:   begin redirect_c = 1'b1; target = targets.jalr;   end
      PC_BRANCH: begin redirect_c = 1'b1; target = targets.branch; end
      PC_JAL:    begin redirect_c = 1'b1; target = targets.jal;    end
      PC_MTVEC:  begin redirect_c = 1'b1; target = targets.mtvec;  end
      PC_MEPC:   begin redirect_c = 1'b1; target = targets.mepc;   end
      default:   ;
    endcase
    if (int_taken) begin
      target = targets.mtvec;
    end
  end

  // Redirect wins over FILL and stall; otherwise hold or advance by one word
  always_comb begin
    pc_next_c = pc_q + XLEN'(4);
    if (redirect_c) begin
      pc_next_c = word_align(target);
    end else if (fill || if_stall) begin
      pc_next_c = pc_q;
    end
  end

endmodule

// File: rtl/otter_fetch_stage.sv
// OTTER instruction fetch: PC register, imem request, stall hold buffer and ID-stage presentation.
module otter_fetch_stage #(
  parameter logic [otter_pkg::XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [otter_pkg::XLEN-1:0] NOP_INSTR    = otter_pkg::NOP_INSTR
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          IF_STALL,
  input  logic [otter_pkg::PCSRC_W-1:0] EX_PCSOURCE,
  input  logic [otter_pkg::XLEN-1:0]    EX_JALR_ADDR,
  input  logic [otter_pkg::XLEN-1:0]    EX_BRANCH_ADDR,
  input  logic [otter_pkg::XLEN-1:0]    EX_JAL_ADDR,
  input  logic [otter_pkg::XLEN-1:0]    CSR_MTVEC,
  input  logic [otter_pkg::XLEN-1:0]    CSR_MEPC,
  input  logic                          INT_TAKEN,
  output logic [otter_pkg::XLEN-1:0]    IMEM_ADDR,
  output logic                          IMEM_RDEN,
  input  logic [otter_pkg::XLEN-1:0]    IMEM_DATA,
  output logic [otter_pkg::XLEN-1:0]    ID_PC,
  output logic [otter_pkg::XLEN-1:0]    ID_PC_PLUS4,
  output logic [otter_pkg::XLEN-1:0]    ID_INSTR,
  output logic [6:0]                    ID_OPCODE,
  output logic [2:0]                    ID_FUNC3,
  output logic [6:0]                    ID_FUNC7,
  output logic                          ID_VALID
);

  import otter_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] hold_q;
  logic [XLEN-1:0] pc_next_c;
  logic [XLEN-1:0] id_word_c;
  logic [XLEN-1:0] id_instr_c;
  logic            redirect_c;
  logic            rden_c;
  logic            fill_c;
  logic            hold_load_c;
  logic            id_valid_c;
  fetch_targets_t  targets;

  assign fill_c  = (state_q == FILL);
  assign targets = '{jalr: EX_JALR_ADDR, branch: EX_BRANCH_ADDR, jal: EX_JAL_ADDR,
                     mtvec: CSR_MTVEC, mepc: CSR_MEPC};

  otter_pc_sel u_pc_sel (
    .pc_q       (pc_q),
    .fill       (fill_c),
    .if_stall   (IF_STALL),
    .pcsource   (EX_PCSOURCE),
    .int_taken  (INT_TAKEN),
    .targets    (targets),
    .redirect_c (redirect_c),
    .pc_next_c  (pc_next_c)
  );

  // A read goes out on redirect, on any unstalled cycle, and unconditionally in FILL; never in reset
  assign rden_c    = RST_N & (redirect_c | ~IF_STALL | fill_c);
  assign IMEM_RDEN = rden_c;
  assign IMEM_ADDR = RST_N ? pc_next_c : RESET_VECTOR;

  // Fetch state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // PC follows the address of every issued read, so it always names the word on IMEM_DATA
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q <= RESET_VECTOR;
    end else if (rden_c) begin
      pc_q <= pc_next_c;
    end
  end

  // Capture the live ID word when a stall begins, since imem output is not held
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_q <= NOP_INSTR;
    end else if (hold_load_c) begin
      hold_q <= IMEM_DATA;
    end
  end

  // Next state and ID word selection; a redirect squashes the ID word in either live state
  always_comb begin
    state_d     = state_q;
    hold_load_c = 1'b0;
    id_valid_c  = 1'b0;
    id_word_c   = NOP_INSTR;
    case (state_q)
      FILL: begin
        state_d = RUN;
      end
      RUN: begin
        id_valid_c = ~redirect_c;
        id_word_c  = IMEM_DATA;
        if (IF_STALL && !redirect_c) begin
          hold_load_c = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        id_valid_c = ~redirect_c;
        id_word_c  = hold_q;
        if (!IF_STALL || redirect_c) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // Dead ID slots present a NOP so the decoder emits no side effects
  assign id_instr_c = id_valid_c ? id_word_c : NOP_INSTR;

  assign ID_VALID    = id_valid_c;
  assign ID_INSTR    = id_instr_c;
  assign ID_OPCODE   = id_instr_c[6:0];
  assign ID_FUNC3    = id_instr_c[14:12];
  assign ID_FUNC7    = id_instr_c[31:25];
  assign ID_PC       = pc_q;
  assign ID_PC_PLUS4 = pc_q + XLEN'(4);

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Vector bench for otter_fetch_stage with a registered-read instruction memory model.
module tb_otter_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BR_D = 32'h0000_0100;
  localparam logic [31:0] JL_D = 32'h0000_0300;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        IF_STALL;
  logic [3:0]  EX_PCSOURCE;
  logic [31:0] EX_JALR_ADDR, EX_BRANCH_ADDR, EX_JAL_ADDR, CSR_MTVEC, CSR_MEPC;
  logic        INT_TAKEN;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_RDEN;
  logic [31:0] IMEM_DATA;
  logic [31:0] ID_PC, ID_PC_PLUS4, ID_INSTR;
  logic [6:0]  ID_OPCODE, ID_FUNC7;
  logic [2:0]  ID_FUNC3;
  logic        ID_VALID;

  otter_fetch_stage dut (
    .CLK(CLK), .RST_N(RST_N), .IF_STALL(IF_STALL), .EX_PCSOURCE(EX_PCSOURCE),
    .EX_JALR_ADDR(EX_JALR_ADDR), .EX_BRANCH_ADDR(EX_BRANCH_ADDR), .EX_JAL_ADDR(EX_JAL_ADDR),
    .CSR_MTVEC(CSR_MTVEC), .CSR_MEPC(CSR_MEPC), .INT_TAKEN(INT_TAKEN),
    .IMEM_ADDR(IMEM_ADDR), .IMEM_RDEN(IMEM_RDEN), .IMEM_DATA(IMEM_DATA),
    .ID_PC(ID_PC), .ID_PC_PLUS4(ID_PC_PLUS4), .ID_INSTR(ID_INSTR),
    .ID_OPCODE(ID_OPCODE), .ID_FUNC3(ID_FUNC3), .ID_FUNC7(ID_FUNC7), .ID_VALID(ID_VALID)
  );

  always #5 CLK = ~CLK;

  // Memory contents: a recognisable word derived from its address
  function automatic logic [31:0] w(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  logic [31:0] mem_q = 32'h0;
  logic        corrupt;

  always @(posedge CLK) if (IMEM_RDEN) mem_q <= w(IMEM_ADDR);
  assign IMEM_DATA = corrupt ? 32'hDEAD_BEEF : mem_q;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic [3:0]  src;
    logic        int_t;
    logic        corrupt;
    logic [31:0] br;
    logic [31:0] jal;
    logic [31:0] addr;
    logic        rden;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic [3:0] src,
                              input logic it, input logic c, input logic [31:0] br,
                              input logic [31:0] jal, input logic [31:0] a, input logic rd,
                              input logic [31:0] pc, input logic [31:0] ins, input logic v);
    vec_t t;
    t.rst_n = r; t.stall = s; t.src = src; t.int_t = it; t.corrupt = c;
    t.br = br; t.jal = jal; t.addr = a; t.rden = rd; t.pc = pc; t.instr = ins; t.valid = v;
    return t;
  endfunction

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Pop the oldest expectation and compare it with what the DUT presents now
  task automatic check();
    vec_t        e;
    logic [31:0] ep4;
    e   = sb.pop_front();
    ep4 = e.pc + 32'd4;
    n_vec++;
    if (IMEM_ADDR !== e.addr || IMEM_RDEN !== e.rden || ID_PC !== e.pc ||
        ID_PC_PLUS4 !== ep4 || ID_INSTR !== e.instr || ID_VALID !== e.valid ||
        ID_OPCODE !== e.instr[6:0] || ID_FUNC3 !== e.instr[14:12] ||
        ID_FUNC7 !== e.instr[31:25]) begin
      n_miss++;
      $display("FAIL vec%0d: got addr=%h rden=%b pc=%h pc4=%h instr=%h op=%h f3=%h f7=%h valid=%b; want addr=%h rden=%b pc=%h pc4=%h instr=%h valid=%b",
               n_vec - 1, IMEM_ADDR, IMEM_RDEN, ID_PC, ID_PC_PLUS4, ID_INSTR, ID_OPCODE,
               ID_FUNC3, ID_FUNC7, ID_VALID, e.addr, e.rden, e.pc, ep4, e.instr, e.valid);
    end
  endtask

  // Drive one cycle of stimulus just after a rising edge, check, then advance
  task automatic apply(input vec_t v);
    RST_N          = v.rst_n;
    IF_STALL       = v.stall;
    EX_PCSOURCE    = v.src;
    INT_TAKEN      = v.int_t;
    corrupt        = v.corrupt;
    EX_BRANCH_ADDR = v.br;
    EX_JAL_ADDR    = v.jal;
    sb.push_back(v);
    #2;
    check();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0; IF_STALL = 1'b0; EX_PCSOURCE = 4'd0; INT_TAKEN = 1'b0; corrupt = 1'b0;
    EX_JALR_ADDR = 32'h0000_0103; EX_BRANCH_ADDR = BR_D; EX_JAL_ADDR = JL_D;
    CSR_MTVEC = 32'h0000_0200; CSR_MEPC = 32'h0000_0044;

    //            rst stl src int cor br    jal   addr          rden pc            instr          valid
    tbl.push_back(mk(0, 0, 0, 0, 0, BR_D, JL_D, 32'h0,        0, 32'h0,        NOP,           0));
    tbl.push_back(mk(1, 0, 0, 0, 0, BR_D, JL_D, 32'h0,        1, 32'h0,        NOP,           0));
    tbl.push_back(mk(1, 0, 0, 0, 0, BR_D, JL_D, 32'h4,        1, 32'h0,        w(32'h0),      1));
    tbl.push_back(mk(1, 0, 0, 0, 0, BR_D, JL_D, 32'h8,        1, 32'h4,        w(32'h4),      1));
    tbl.push_back(mk(1, 1, 0, 0, 0, BR_D, JL_D, 32'h8,        0, 32'h8,        w(32'h8),      1));
    tbl.push_back(mk(1, 1, 0, 0, 1, BR_D, JL_D, 32'h8,        0, 32'h8,        w(32'h8),      1));
    tbl.push_back(mk(1, 1, 0, 0, 1, BR_D, JL_D, 32'h8,        0, 32'h8,        w(32'h8),      1));
    tbl.push_back(mk(1, 0, 0, 0, 1, BR_D, JL_D, 32'hC,        1, 32'h8,        w(32'h8),      1));
    tbl.push_back(mk(1, 0, 0, 0, 0, BR_D, JL_D, 32'h10,       1, 32'hC,        w(32'hC),      1));
    tbl.push_back(mk(1, 0, 2, 0, 0, BR_D, JL_D, 32'h100,      1, 32'h10,       NOP,           0));
    tbl.push_back(mk(1, 0, 0, 0, 0, BR_D, JL_D, 32'h104,      1, 32'h100,      w(32'h100),    1));
    tbl.push_back(mk(1, 1, 3, 1, 0, BR_D, JL_D, 32'h200,      1, 32'h104,      NOP,           0));
    tbl.push_back(mk(1, 0, 0, 0, 0, BR_D, JL_D, 32'h204,      1, 32'h200,      w(32'h200),    1));
    tbl.push_back(mk(1, 0, 5, 0, 0, BR_D, JL_D, 32'h44,       1, 32'h204,      NOP,           0));
    tbl.push_back(mk(1, 0, 0, 0, 0, BR_D, JL_D, 32'h48,       1, 32'h44,       w(32'h44),     1));

    #1;
    foreach (tbl[i]) apply(tbl[i]);

    // Misaligned JALR target, with branch target moved so the two sources are distinguishable
    apply(mk(1, 0, 1, 0, 0, 32'h600, JL_D, 32'h100, 1, 32'h48,  NOP,        0));
    // Reserved source encoding behaves as sequential
    apply(mk(1, 0, 9, 0, 0, BR_D,    JL_D, 32'h104, 1, 32'h100, w(32'h100), 1));
    apply(mk(1, 0, 3, 0, 0, BR_D,    JL_D, 32'h300, 1, 32'h104, NOP,        0));
    apply(mk(1, 0, 0, 0, 0, BR_D,    JL_D, 32'h304, 1, 32'h300, w(32'h300), 1));

    // Jump to the top word and wrap the PC to zero
    apply(mk(1, 0, 3, 0, 0, BR_D, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1, 32'h304,       NOP,               0));
    apply(mk(1, 0, 0, 0, 0, BR_D, JL_D,          32'h0,         1, 32'hFFFF_FFFC, w(32'hFFFF_FFFC),  1));
    apply(mk(1, 0, 0, 0, 0, BR_D, JL_D,          32'h4,         1, 32'h0,         w(32'h0),          1));

    // Enter HOLD, then assert reset mid-cycle; outputs must drop before the next edge
    apply(mk(1, 1, 0, 0, 0, BR_D, JL_D, 32'h4, 0, 32'h4, w(32'h4), 1));
    apply(mk(1, 1, 0, 0, 1, BR_D, JL_D, 32'h4, 0, 32'h4, w(32'h4), 1));
    apply(mk(0, 1, 0, 0, 1, BR_D, JL_D, 32'h0, 0, 32'h0, NOP,      0));
    // FILL ignores the stall and restarts at the reset vector
    apply(mk(1, 1, 0, 0, 0, BR_D, JL_D, 32'h0, 1, 32'h0, NOP,      0));
    apply(mk(1, 0, 0, 0, 0, BR_D, JL_D, 32'h4, 1, 32'h0, w(32'h0), 1));

    // Redirect arriving while in HOLD beats the ongoing stall
    apply(mk(1, 1, 0, 0, 0, BR_D, JL_D, 32'h4,   0, 32'h4,   w(32'h4),   1));
    apply(mk(1, 1, 2, 0, 1, BR_D, JL_D, 32'h100, 1, 32'h4,   NOP,        0));
    apply(mk(1, 0, 0, 0, 0, BR_D, JL_D, 32'h104, 1, 32'h100, w(32'h100), 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
